// File: rtl/game_ctrl.sv
// Pong match sequencer: runs idle/serve/play/pause/point/over, keeps both scores,
// gates and recentres the ball engine and drives the status LEDs.
module game_ctrl #(
   parameter int SCORE_W      = 4,
   parameter int WIN_SCORE    = 9,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 90,
   parameter int LEDS_W       = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               frame_tick_i,
   input  logic               start_key_i,
   input  logic               miss_l_i,
   input  logic               miss_r_i,
   output logic               ball_en_o,
   output logic               ball_rst_o,
   output logic               serve_dir_o,
   output logic [SCORE_W-1:0] score_l_o,
   output logic [SCORE_W-1:0] score_r_o,
   output logic               winner_o,
   output logic [2:0]         state_o,
   output logic [LEDS_W-1:0]  leds_o
);

   localparam int MAXF  = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
   localparam int CNT_W = $clog2(MAXF + 1);
   localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      PAUSE = 3'd3,
      POINT = 3'd4,
      OVER  = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
   logic               dir_q, dir_d;
   logic               winner_q, winner_d;
   logic               key_q;
   logic               ball_en_q, ball_rst_q;
   logic [LEDS_W-1:0]  leds_q, leds_d;
   logic               start;

   always_comb begin
      start     = start_key_i & ~key_q;
      state_d   = state_q;
      score_l_d = score_l_q;
      score_r_d = score_r_q;
      dir_d     = dir_q;
      winner_d  = winner_q;
      case (state_q)
         IDLE, OVER: begin
            if (start) begin
               score_l_d = '0;
               score_r_d = '0;
               state_d   = SERVE;
            end
         end
         SERVE: begin
            if (frame_tick_i && cnt_q == CNT_W'(SERVE_FRAMES - 1)) state_d = PLAY;
         end
         PLAY: begin
            // a miss always beats a simultaneous start press
            if (miss_l_i && miss_r_i) begin
               dir_d   = ~dir_q;
               state_d = POINT;
            end else if (miss_l_i) begin
               if (score_r_q < WIN) score_r_d = score_r_q + SCORE_W'(1);
               dir_d   = 1'b0;
               state_d = POINT;
            end else if (miss_r_i) begin
               if (score_l_q < WIN) score_l_d = score_l_q + SCORE_W'(1);
               dir_d   = 1'b1;
               state_d = POINT;
            end else if (start) begin
               state_d = PAUSE;
            end
         end
         PAUSE: begin
            if (start) state_d = PLAY;
         end
         POINT: begin
            if (frame_tick_i && cnt_q == CNT_W'(POINT_FRAMES - 1))
               state_d = (score_l_q == WIN || score_r_q == WIN) ? OVER : SERVE;
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q)
         cnt_d = '0;
      else if (frame_tick_i && (state_q == SERVE || state_q == POINT))
         cnt_d = cnt_q + CNT_W'(1);
      else
         cnt_d = cnt_q;

      if (state_d == OVER && state_q != OVER) winner_d = (score_r_q == WIN);

      leds_d = '0;
      leds_d[0] = (state_d == PLAY);
      leds_d[1] = (state_d == PAUSE);
      leds_d[2] = (state_d == OVER);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         score_l_q  <= '0;
         score_r_q  <= '0;
         dir_q      <= 1'b0;
         winner_q   <= 1'b0;
         key_q      <= 1'b1;
         ball_en_q  <= 1'b0;
         ball_rst_q <= 1'b1;
         leds_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         score_l_q  <= score_l_d;
         score_r_q  <= score_r_d;
         dir_q      <= dir_d;
         winner_q   <= winner_d;
         key_q      <= start_key_i;
         ball_en_q  <= (state_d == PLAY);
         ball_rst_q <= (state_d == IDLE || state_d == SERVE || state_d == OVER);
         leds_q     <= leds_d;
      end
   end

   assign ball_en_o   = ball_en_q;
   assign ball_rst_o  = ball_rst_q;
   assign serve_dir_o = dir_q;
   assign score_l_o   = score_l_q;
   assign score_r_o   = score_r_q;
   assign winner_o    = winner_q;
   assign state_o     = state_q;
   assign leds_o      = leds_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: directed match scenarios followed by random play,
// expected outputs come from a phase/score reference model.
module tb_game_ctrl;
   localparam int SW = 4, WINS = 3, SRV = 2, PNT = 3, LW = 4;

   logic clk = 1'b0;
   logic rst_i = 1'b1, frame_tick_i = 1'b0, start_key_i = 1'b0, miss_l_i = 1'b0, miss_r_i = 1'b0;
   logic ball_en_o, ball_rst_o, serve_dir_o, winner_o;
   logic [SW-1:0] score_l_o, score_r_o;
   logic [2:0] state_o;
   logic [LW-1:0] leds_o;

   game_ctrl #(.SCORE_W(SW), .WIN_SCORE(WINS), .SERVE_FRAMES(SRV), .POINT_FRAMES(PNT), .LEDS_W(LW)) dut (
      .clk_i(clk), .rst_i(rst_i), .frame_tick_i(frame_tick_i), .start_key_i(start_key_i),
      .miss_l_i(miss_l_i), .miss_r_i(miss_r_i), .ball_en_o(ball_en_o), .ball_rst_o(ball_rst_o),
      .serve_dir_o(serve_dir_o), .score_l_o(score_l_o), .score_r_o(score_r_o),
      .winner_o(winner_o), .state_o(state_o), .leds_o(leds_o));

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   logic [18:0] exp_q[$];
   string tag_q[$];
   string cur_tag = "reset";

   // reference: phase 0..5 = idle,serve,play,pause,point,over
   int ph = 0, sl = 0, sr = 0, dir = 0, win = 0, ticks = 0, kprev = 1;

   task automatic model(input bit r, input bit tk, input bit k, input bit ml, input bit mr);
      int nph;
      bit st;
      if (r) begin
         ph = 0; sl = 0; sr = 0; dir = 0; win = 0; ticks = 0; kprev = 1;
         return;
      end
      st = k && !kprev;
      kprev = k;
      nph = ph;
      case (ph)
         0, 5: if (st) begin sl = 0; sr = 0; nph = 1; end
         1: if (tk) begin ticks++; if (ticks == SRV) nph = 2; end
         2: begin
            if (ml && mr) begin dir = 1 - dir; nph = 4; end
            else if (ml) begin sr = (sr + 1 > WINS) ? WINS : sr + 1; dir = 0; nph = 4; end
            else if (mr) begin sl = (sl + 1 > WINS) ? WINS : sl + 1; dir = 1; nph = 4; end
            else if (st) nph = 3;
         end
         3: if (st) nph = 2;
         4: if (tk) begin ticks++; if (ticks == PNT) nph = (sl == WINS || sr == WINS) ? 5 : 1; end
         default: nph = 0;
      endcase
      if (nph != ph) begin
         ticks = 0;
         if (nph == 5) win = (sr == WINS) ? 1 : 0;
      end
      ph = nph;
   endtask

   function automatic logic [18:0] expected();
      logic [3:0] l;
      l = (ph == 2) ? 4'b0001 : (ph == 3) ? 4'b0010 : (ph == 5) ? 4'b0100 : 4'b0000;
      return {ph[2:0], 1'(ph == 2), 1'(ph == 0 || ph == 1 || ph == 5), dir[0],
              sl[3:0], sr[3:0], win[0], l};
   endfunction

   task automatic cyc(input bit r, input bit tk, input bit k, input bit ml, input bit mr);
      @(posedge clk);
      #2;
      rst_i = r; frame_tick_i = tk; start_key_i = k; miss_l_i = ml; miss_r_i = mr;
      model(r, tk, k, ml, mr);
      exp_q.push_back(expected());
      tag_q.push_back(cur_tag);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0, 0, 0);
   endtask

   task automatic ticks_n(input int n);
      repeat (n) begin cyc(0, 1, 0, 0, 0); idle(2); end
   endtask

   task automatic press();
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0);
   endtask

   // monitor: compares every cycle that has an expectation queued
   initial begin
      logic [18:0] e, a;
      string t;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {state_o, ball_en_o, ball_rst_o, serve_dir_o, score_l_o, score_r_o, winner_o, leds_o};
            checks++;
            if (a !== e) begin
               failures++;
               $display("FAIL %s t=%0t got st=%0d en=%b rst=%b dir=%b sl=%0d sr=%0d w=%b leds=%b exp st=%0d en=%b rst=%b dir=%b sl=%0d sr=%0d w=%b leds=%b",
                        t, $time, a[18:16], a[15], a[14], a[13], a[12:9], a[8:5], a[4], a[3:0],
                        e[18:16], e[15], e[14], e[13], e[12:9], e[8:5], e[4], e[3:0]);
            end
         end
      end
   end

   initial begin
      cur_tag = "key_held_reset";
      repeat (3) cyc(1, 0, 1, 0, 0);
      repeat (4) cyc(0, 0, 1, 0, 0);
      cur_tag = "idle_no_tick";
      idle(2);
      cyc(0, 1, 0, 0, 0);
      idle(3);
      cur_tag = "start_to_serve";
      press();
      cur_tag = "serve_ticks";
      idle(4);
      ticks_n(2);
      cur_tag = "miss_l";
      cyc(0, 0, 0, 1, 0);
      cur_tag = "point_ticks";
      ticks_n(3);
      ticks_n(2);
      cur_tag = "double_miss";
      cyc(0, 0, 0, 1, 1);
      ticks_n(3);
      ticks_n(2);
      cur_tag = "pause";
      press();
      cyc(0, 0, 0, 0, 1);
      cyc(0, 1, 0, 0, 0);
      press();
      cur_tag = "miss_with_start";
      cyc(0, 0, 1, 1, 0);
      cyc(0, 0, 0, 0, 0);
      ticks_n(3);
      ticks_n(2);
      cur_tag = "right_wins";
      cyc(0, 0, 0, 1, 0);
      ticks_n(3);
      cur_tag = "over";
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1);
      ticks_n(2);
      cur_tag = "restart";
      press();
      ticks_n(2);
      cur_tag = "reset_in_point";
      cyc(0, 0, 0, 0, 1);
      ticks_n(1);
      cyc(1, 0, 0, 0, 0);
      idle(3);
      cur_tag = "random";
      begin
         bit k = 1'b0;
         for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) k = ~k;
            cyc($urandom_range(0, 399) == 0, $urandom_range(0, 2) == 0, k,
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
         end
      end
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
